addr_route_decode: RTL and testbench



---
 rtl/addr_route_decode.sv | 214 +++++++++++++++++++++
 tb/tb_addr_route_decode.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_route_decode.sv
// addr_route_decode: classifies 27-bit fabric addresses into a destination class, id and offset,
// flags unmapped addresses, and forwards results through a registered 2-entry skid buffer.
// Address layout follows addr_t (test_pkg_c_rypkg); fields are sliced locally so this file
// stands alone.
// Optional build macro: ADDR_ROUTE_DECODE_ERR_LOG_EN adds a sticky capture of the first
// errored address (err_log_valid / err_log_addr).
module addr_route_decode #(
    parameter int unsigned TAG_W     = 8,
    parameter int unsigned ERR_DROP  = 0,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [26:0]          in_addr,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_class,
    output logic [9:0]           out_id,
    output logic [22:0]          out_offset,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt,
`ifdef ADDR_ROUTE_DECODE_ERR_LOG_EN
    output logic                 err_log_valid,
    output logic [26:0]          err_log_addr,
`endif
    input  logic                 err_cnt_clr
);

    localparam bit DropErr = (ERR_DROP != 0);
    localparam logic [ERR_CNT_W-1:0] CntOne = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [2:0]       cls;
        logic [9:0]       id;
        logic [22:0]      offset;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // Address fields
    logic       is_zap;
    logic       is_csr;
    logic [2:0] zap_rack_id;
    logic [2:0] zap_id;
    logic [3:0] zap_block_id;
    logic [2:0] nz_block_id;
    logic [2:0] rk_rack_id;
    logic [1:0] rk_block_id;
    logic [2:0] rk_inst;

    assign is_zap       = in_addr[26];
    assign is_csr       = in_addr[25];
    assign zap_rack_id  = in_addr[24:22];
    assign zap_id       = in_addr[21:19];
    assign zap_block_id = in_addr[18:15];
    assign nz_block_id  = in_addr[25:23];
    assign rk_rack_id   = in_addr[22:20];
    assign rk_block_id  = in_addr[19:18];
    assign rk_inst      = in_addr[17:15];

    logic   dec_err;
    entry_t dec_entry;

    // Combinational decode of the incoming address
    always_comb begin
        dec_err          = 1'b0;
        dec_entry.cls    = 3'd0;
        dec_entry.id     = 10'd0;
        dec_entry.offset = 23'd0;
        dec_entry.tag    = in_tag;
        if (is_zap) begin
            if (!is_csr) begin
                dec_entry.cls    = 3'd0;
                dec_entry.id     = {4'b0, zap_rack_id, zap_id};
                dec_entry.offset = {4'b0, in_addr[18:0]};
            end else if (zap_block_id >= 4'd1 && zap_block_id <= 4'd12) begin
                dec_entry.cls    = 3'd1;
                dec_entry.id     = {zap_rack_id, zap_id, zap_block_id};
                dec_entry.offset = {8'b0, in_addr[14:0]};
            end else begin
                dec_err = 1'b1;
            end
        end else if (nz_block_id == 3'd3) begin
            dec_err = 1'b1;
        end else if (nz_block_id == 3'd6) begin
            // Rack block 3 is unmapped; ICE has a single instance
            if (rk_block_id == 2'd3 || (rk_block_id == 2'd0 && rk_inst != 3'd0)) begin
                dec_err = 1'b1;
            end else begin
                dec_entry.cls    = 3'd3;
                dec_entry.id     = {2'b0, rk_rack_id, rk_block_id, rk_inst};
                dec_entry.offset = {8'b0, in_addr[14:0]};
            end
        end else begin
            dec_entry.cls    = 3'd2;
            dec_entry.id     = {7'b0, nz_block_id};
            dec_entry.offset = in_addr[22:0];
        end
        if (dec_err) begin
            dec_entry.cls    = 3'd7;
            dec_entry.id     = 10'd0;
            dec_entry.offset = in_addr[22:0];
        end
    end

    // Skid buffer: head drives the outputs, skid holds the overflow entry
    logic   head_valid_q, head_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   accept;
    logic   push;
    logic   pop;

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & in_ready;
    assign push     = accept & ~(DropErr & dec_err);
    assign pop      = head_valid_q & out_ready;

    // Next-state for the buffer, preserving order on simultaneous push and pop
    always_comb begin
        head_valid_d = head_valid_q;
        head_d       = head_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (pop) begin
            if (skid_valid_q) begin
                head_d       = skid_q;
                skid_valid_d = push;
                if (push) skid_d = dec_entry;
            end else begin
                head_valid_d = push;
                if (push) head_d = dec_entry;
            end
        end else if (push) begin
            if (!head_valid_q) begin
                head_valid_d = 1'b1;
                head_d       = dec_entry;
            end else begin
                skid_valid_d = 1'b1;
                skid_d       = dec_entry;
            end
        end
    end

    // Buffer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            head_q       <= '0;
            skid_q       <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid  = head_valid_q;
    assign out_class  = head_q.cls;
    assign out_id     = head_q.id;
    assign out_offset = head_q.offset;
    assign out_tag    = head_q.tag;

    logic                 err_pulse_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Error pulse and saturating counter; clear beats a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= accept & dec_err;
            if (err_cnt_clr) begin
                err_cnt_q <= '0;
            end else if (err_pulse_q && !(&err_cnt_q)) begin
                err_cnt_q <= err_cnt_q + CntOne;
            end
        end
    end

    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

`ifdef ADDR_ROUTE_DECODE_ERR_LOG_EN
    logic        log_valid_q;
    logic [26:0] log_addr_q;

    // Sticky capture of the first errored address since reset or clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_valid_q <= 1'b0;
            log_addr_q  <= '0;
        end else if (err_cnt_clr) begin
            log_valid_q <= 1'b0;
        end else if (accept && dec_err && !log_valid_q) begin
            log_valid_q <= 1'b1;
            log_addr_q  <= in_addr;
        end
    end

    assign err_log_valid = log_valid_q;
    assign err_log_addr  = log_addr_q;
`else
    // Error log not built
`endif

endmodule

// File: tb/tb_addr_route_decode.sv
// Directed bench for addr_route_decode. Instance a: defaults (errors forwarded, 16-bit count).
// Instance b: errors dropped, 4-bit count.
module tb_addr_route_decode;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err_pulse, a_err_cnt_clr;
    logic [26:0] a_in_addr;
    logic [7:0]  a_in_tag, a_out_tag;
    logic [2:0]  a_out_class;
    logic [9:0]  a_out_id;
    logic [22:0] a_out_offset;
    logic [15:0] a_err_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err_pulse, b_err_cnt_clr;
    logic [26:0] b_in_addr;
    logic [7:0]  b_in_tag, b_out_tag;
    logic [2:0]  b_out_class;
    logic [9:0]  b_out_id;
    logic [22:0] b_out_offset;
    logic [3:0]  b_err_cnt;

`ifdef ADDR_ROUTE_DECODE_ERR_LOG_EN
    logic        a_log_valid, b_log_valid;
    logic [26:0] a_log_addr, b_log_addr;
`endif

    addr_route_decode #(.TAG_W(8), .ERR_DROP(0), .ERR_CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_addr(a_in_addr), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_class(a_out_class),
        .out_id(a_out_id), .out_offset(a_out_offset), .out_tag(a_out_tag),
        .err_pulse(a_err_pulse), .err_cnt(a_err_cnt),
`ifdef ADDR_ROUTE_DECODE_ERR_LOG_EN
        .err_log_valid(a_log_valid), .err_log_addr(a_log_addr),
`endif
        .err_cnt_clr(a_err_cnt_clr)
    );

    addr_route_decode #(.TAG_W(8), .ERR_DROP(1), .ERR_CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_addr(b_in_addr), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_class(b_out_class),
        .out_id(b_out_id), .out_offset(b_out_offset), .out_tag(b_out_tag),
        .err_pulse(b_err_pulse), .err_cnt(b_err_cnt),
`ifdef ADDR_ROUTE_DECODE_ERR_LOG_EN
        .err_log_valid(b_log_valid), .err_log_addr(b_log_addr),
`endif
        .err_cnt_clr(b_err_cnt_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0b want 0", a_out_valid); end
        n_cmp++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %0b want 1", a_in_ready); end
        n_cmp++; if ({a_out_class, a_out_id, a_out_offset, a_out_tag} !== '0) begin n_fail++;
            $display("FAIL rst_out_fields got %h/%h/%h/%h want 0", a_out_class, a_out_id, a_out_offset, a_out_tag); end
        n_cmp++; if (a_err_pulse !== 1'b0 || a_err_cnt !== 16'd0) begin n_fail++;
            $display("FAIL rst_err got pulse %0b cnt %0d want 0/0", a_err_pulse, a_err_cnt); end
        n_cmp++; if (b_in_ready !== 1'b1 || b_err_cnt !== 4'd0) begin n_fail++;
            $display("FAIL rst_b got rdy %0b cnt %0d want 1/0", b_in_ready, b_err_cnt); end
    endtask

    // Back-to-back decode vectors with out_ready held high
    task automatic test_decode();
        logic [26:0] v_addr [10];
        logic [2:0]  v_cls  [10];
        logic [9:0]  v_id   [10];
        logic [22:0] v_off  [10];
        logic        v_err  [10];
        v_addr = '{27'h4A81234, 27'h6000000, 27'h6060000, 27'h1123456, 27'h1800055,
                   27'h35B9ABC, 27'h30C0000, 27'h6068000, 27'h3008000, 27'h3107FFF};
        v_cls  = '{3'd0, 3'd7, 3'd1, 3'd2, 3'd7, 3'd3, 3'd7, 3'd7, 3'd7, 3'd3};
        v_id   = '{10'h015, 10'h000, 10'h00C, 10'h002, 10'h000,
                   10'h0B7, 10'h000, 10'h000, 10'h000, 10'h020};
        v_off  = '{23'h01234, 23'h0, 23'h0, 23'h123456, 23'h55,
                   23'h1ABC, 23'h0C0000, 23'h068000, 23'h008000, 23'h7FFF};
        v_err  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        a_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_in_valid = 1'b1;
            a_in_addr  = v_addr[i];
            a_in_tag   = 8'(8'h5A + i);
            step();
            n_cmp++; if (a_out_valid !== 1'b1 || a_out_class !== v_cls[i] || a_out_id !== v_id[i] ||
                         a_out_offset !== v_off[i] || a_out_tag !== 8'(8'h5A + i)) begin
                n_fail++;
                $display("FAIL decode[%0d] got v%0b c%0d id%h off%h tag%h want v1 c%0d id%h off%h tag%h",
                         i, a_out_valid, a_out_class, a_out_id, a_out_offset, a_out_tag,
                         v_cls[i], v_id[i], v_off[i], 8'(8'h5A + i));
            end
            n_cmp++; if (a_err_pulse !== v_err[i]) begin n_fail++;
                $display("FAIL decode_err_pulse[%0d] got %0b want %0b", i, a_err_pulse, v_err[i]); end
        end
        a_in_valid = 1'b0;
        step();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL decode_drain got %0b want 0", a_out_valid); end
        n_cmp++; if (a_err_cnt !== 16'd5) begin n_fail++; $display("FAIL decode_err_cnt got %0d want 5", a_err_cnt); end
    endtask

    task automatic test_drop();
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_addr = 27'h3008000; b_in_tag = 8'hC1;
        step();
        b_in_valid = 1'b0;
        n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_no_out got %0b want 0", b_out_valid); end
        n_cmp++; if (b_err_pulse !== 1'b1) begin n_fail++; $display("FAIL drop_pulse got %0b want 1", b_err_pulse); end
`ifdef ADDR_ROUTE_DECODE_ERR_LOG_EN
        n_cmp++; if (b_log_valid !== 1'b1 || b_log_addr !== 27'h3008000) begin n_fail++;
            $display("FAIL drop_log got %0b %h want 1 3008000", b_log_valid, b_log_addr); end
`endif
        step();
        n_cmp++; if (b_err_pulse !== 1'b0 || b_err_cnt !== 4'd1) begin n_fail++;
            $display("FAIL drop_cnt got pulse %0b cnt %0d want 0/1", b_err_pulse, b_err_cnt); end
        b_in_valid = 1'b1; b_in_addr = 27'h4A81234; b_in_tag = 8'h5A;
        step();
        b_in_valid = 1'b0;
        n_cmp++; if (b_out_valid !== 1'b1 || b_out_class !== 3'd0 || b_out_id !== 10'h015 ||
                     b_out_tag !== 8'h5A) begin n_fail++;
            $display("FAIL drop_good got v%0b c%0d id%h tag%h want v1 c0 id015 tag5a",
                     b_out_valid, b_out_class, b_out_id, b_out_tag); end
        b_in_valid = 1'b1; b_in_addr = 27'h6000000; b_in_tag = 8'hC2;
        step();
        b_in_valid = 1'b0;
        n_cmp++; if (b_out_valid !== 1'b0 || b_err_pulse !== 1'b1) begin n_fail++;
            $display("FAIL drop_second got v%0b pulse %0b want 0/1", b_out_valid, b_err_pulse); end
`ifdef ADDR_ROUTE_DECODE_ERR_LOG_EN
        n_cmp++; if (b_log_addr !== 27'h3008000) begin n_fail++;
            $display("FAIL drop_log_sticky got %h want 3008000", b_log_addr); end
`endif
        step();
        n_cmp++; if (b_err_cnt !== 4'd2) begin n_fail++; $display("FAIL drop_cnt2 got %0d want 2", b_err_cnt); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got = 0;
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_addr = 27'h1000001; a_in_tag = 8'd1;
        for (int c = 0; c < 6; c++) begin
            if (a_in_valid && a_in_ready) sent++;
            step();
            if (sent == 4) a_in_valid = 1'b0;
            else begin a_in_addr = 27'h1000000 | 27'(sent + 1); a_in_tag = 8'(sent + 1); end
        end
        n_cmp++; if (sent != 2) begin n_fail++; $display("FAIL bp_accepts got %0d want 2", sent); end
        n_cmp++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %0b want 0", a_in_ready); end
        n_cmp++; if (a_out_valid !== 1'b1 || a_out_tag !== 8'd1 || a_out_offset !== 23'd1) begin n_fail++;
            $display("FAIL bp_stable got v%0b tag%0d off%0d want 1/1/1", a_out_valid, a_out_tag, a_out_offset); end
        a_out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (a_out_valid && a_out_ready) begin
                n_cmp++; if (a_out_tag !== 8'(got + 1) || a_out_offset !== 23'(got + 1)) begin n_fail++;
                    $display("FAIL bp_order[%0d] got tag%0d off%0d want %0d", got, a_out_tag, a_out_offset, got + 1); end
                got++;
            end
            if (a_in_valid && a_in_ready) sent++;
            step();
            if (sent == 4) a_in_valid = 1'b0;
            else begin a_in_addr = 27'h1000000 | 27'(sent + 1); a_in_tag = 8'(sent + 1); end
        end
        n_cmp++; if (got != 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", got); end
    endtask

    task automatic test_saturation();
        b_err_cnt_clr = 1'b1;
        step();
        b_err_cnt_clr = 1'b0;
        n_cmp++; if (b_err_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clr got %0d want 0", b_err_cnt); end
`ifdef ADDR_ROUTE_DECODE_ERR_LOG_EN
        n_cmp++; if (b_log_valid !== 1'b0) begin n_fail++; $display("FAIL sat_log_clr got %0b want 0", b_log_valid); end
`endif
        b_in_valid = 1'b1; b_in_addr = 27'h1800055; b_in_tag = 8'hEE;
        for (int i = 0; i < 17; i++) step();
        b_in_valid = 1'b0;
        step();
        step();
        n_cmp++; if (b_err_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_value got %0d want 15", b_err_cnt); end
        b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        b_err_cnt_clr = 1'b1;
        step();
        b_err_cnt_clr = 1'b0;
        n_cmp++; if (b_err_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clr_wins got %0d want 0", b_err_cnt); end
        step();
        n_cmp++; if (b_err_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_clr_hold got %0d want 0", b_err_cnt); end
    endtask

    task automatic test_reset_mid();
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_addr = 27'h1000007; a_in_tag = 8'd7;
        step();
        a_in_addr = 27'h1000008; a_in_tag = 8'd8;
        step();
        a_in_valid = 1'b0;
        n_cmp++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin n_fail++;
            $display("FAIL rmid_full got rdy%0b v%0b want 0/1", a_in_ready, a_out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_tag !== 8'd0) begin n_fail++;
            $display("FAIL rmid_async got v%0b rdy%0b tag%0d want 0/1/0", a_out_valid, a_in_ready, a_out_tag); end
        step();
        step();
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_addr = 27'h1000009; a_in_tag = 8'd9;
        step();
        a_in_valid = 1'b0;
        n_cmp++; if (a_out_valid !== 1'b1 || a_out_tag !== 8'd9 || a_out_offset !== 23'd9) begin n_fail++;
            $display("FAIL rmid_first got v%0b tag%0d off%0d want 1/9/9", a_out_valid, a_out_tag, a_out_offset); end
        step();
        n_cmp++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_drain got %0b want 0", a_out_valid); end
    endtask

    initial begin
        a_in_valid = 1'b0; a_in_addr = '0; a_in_tag = '0; a_out_ready = 1'b0; a_err_cnt_clr = 1'b0;
        b_in_valid = 1'b0; b_in_addr = '0; b_in_tag = '0; b_out_ready = 1'b0; b_err_cnt_clr = 1'b0;
        test_reset();
        test_decode();
        test_drop();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
